// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory initiator and its SCLK generator.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: owns the half-period counter and marks the rise, sample and fall cycles.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_pulse_o,
    output logic sample_pulse_o,
    output logic fall_pulse_o
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             fall_q;
    logic             wrap;

    assign wrap = (div_q == DIV_LAST);

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (wrap) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
            fall_q <= sample_pulse_o;
        end
    end

    // A fall only follows a completed high phase, so the first low phase never pulses.
    assign sclk_o         = sclk_q;
    assign rise_pulse_o   = en_i && sclk_q && (div_q == '0);
    assign sample_pulse_o = en_i && sclk_q && wrap;
    assign fall_pulse_o   = en_i && fall_q;

endmodule

// File: rtl/spi_master.sv
// SPI initiator for the 7-bit-address byte memory: one command in, one 16-bit mode-0 frame out.
// state | meaning
// IDLE  | waiting for start; command fields latched on accept
// SETUP | cs_n low, first bit on mosi, sclk low for CLK_DIV cycles
// SHIFT | 16 bits, each CLK_DIV low then CLK_DIV high cycles
// HOLD  | cs_n low, sclk low for CLK_DIV cycles after the last bit
// GAP   | cs_n high for CS_IDLE cycles; done on the last one
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam int               GAP_W    = $clog2(CS_IDLE + 1);
    localparam int               BIT_W    = $clog2(FRAME_BITS);
    localparam logic [DIV_W-1:0] PH_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(FRAME_BITS - 1);

    spi_state_e            state_q, state_d;
    logic [DIV_W-1:0]      ph_cnt_q, ph_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  last_q, last_d;
    logic                  rw_q, rw_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [DATA_W-2:0]     rx_q, rx_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [DATA_W-1:0]     tx_low;

    logic shift_en;
    logic sclk_int;
    logic rise_pulse;
    logic sample_pulse;
    logic fall_pulse;

    assign shift_en = (state_q == SHIFT);
    assign tx_low   = (rw == RW_WRITE) ? wdata : '0;

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk           (clk),
        .reset         (reset),
        .en_i          (shift_en),
        .sclk_o        (sclk_int),
        .rise_pulse_o  (rise_pulse),
        .sample_pulse_o(sample_pulse),
        .fall_pulse_o  (fall_pulse)
    );

    always_comb begin
        state_d   = state_q;
        ph_cnt_d  = ph_cnt_q;
        gap_cnt_d = gap_cnt_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        rw_d      = rw_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETUP;
                    rw_d      = rw;
                    tx_d      = {addr, rw, tx_low};
                    ph_cnt_d  = PH_LOAD;
                    bit_cnt_d = BIT_LOAD;
                    last_d    = 1'b0;
                end
            end
            SETUP: begin
                if (ph_cnt_q == '0) begin
                    state_d = SHIFT;
                end else begin
                    ph_cnt_d = ph_cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (fall_pulse) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
                // Final-bit flag is settled at the rise so the exit decode at sample is one flop.
                if (rise_pulse) begin
                    last_d = (bit_cnt_q == '0);
                end
                if (sample_pulse) begin
                    tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                    rx_d = {rx_q[DATA_W-3:0], miso};
                    if (last_q) begin
                        state_d  = HOLD;
                        ph_cnt_d = PH_LOAD;
                        if (rw_q == RW_READ) begin
                            rdata_d = {rx_q, miso};
                        end
                    end
                end
            end
            HOLD: begin
                if (ph_cnt_q == '0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    ph_cnt_d = ph_cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ph_cnt_q  <= '0;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            rw_q      <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ph_cnt_q  <= ph_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            rw_q      <= rw_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == GAP) && (gap_cnt_q == '0);
    assign cs_n  = !((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));
    assign sclk  = sclk_int;
    assign mosi  = tx_q[FRAME_BITS-1];
    assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboarded bench for spi_master: byte-memory reference model, bit-level SPI memory on the bus.
module tb_spi_master;

    localparam int CLK_DIV = 4;
    localparam int CS_IDLE = 4;
    localparam int LAT     = 34 * CLK_DIV + CS_IDLE;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem[128];
    logic [7:0]  slv_mem[128];
    logic [7:0]  model_rdata;
    logic [7:0]  hold_rdata;
    logic [15:0] last_frame;
    int          last_rises;

    spi_master #(
        .CLK_DIV(CLK_DIV),
        .CS_IDLE(CS_IDLE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .rw   (rw),
        .addr (addr),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .rdata(rdata),
        .sclk (sclk),
        .cs_n (cs_n),
        .mosi (mosi),
        .miso (miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 42) return 8'h5C;
        return 8'(i * 73 + 29) ^ 8'h96;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // SPI memory on the wire: samples mosi at sclk rise, launches miso after sclk fall.
    initial begin : slave
        logic [15:0] sh;
        int          nrises;
        logic        prev_sclk;
        logic        prev_cs;
        logic [6:0]  s_addr;
        logic        s_rd;
        for (int i = 0; i < 128; i++) slv_mem[i] = init_byte(i);
        sh = '0; nrises = 0; prev_sclk = 1'b0; prev_cs = 1'b1;
        s_addr = '0; s_rd = 1'b0; miso = 1'b0;
        last_frame = '0; last_rises = 0;
        forever begin
            @(negedge clk);
            if (cs_n) begin
                if (!prev_cs) begin
                    last_rises = nrises;
                    if (nrises == 16) begin
                        last_frame = sh;
                        if (!sh[8]) slv_mem[sh[15:9]] = sh[7:0];
                    end
                end
                nrises = 0;
                miso   = 1'b0;
            end else begin
                if (prev_cs) begin
                    last_rises = -1;
                    last_frame = '0;
                end
                if (sclk && !prev_sclk) begin
                    sh = {sh[14:0], mosi};
                    nrises++;
                end
                if (!sclk && prev_sclk && nrises >= 8 && nrises < 16) begin
                    if (nrises == 8) begin
                        s_addr = sh[7:1];
                        s_rd   = sh[0];
                    end
                    miso = s_rd ? slv_mem[s_addr][15 - nrises] : 1'b0;
                end
            end
            prev_sclk = sclk;
            prev_cs   = cs_n;
        end
    end

    initial begin : monitor
        exp_t e;
        hold_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                hold_rdata = 8'h00;
            end else if (done) begin
                check("done_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("latency", cyc + 1 - e.acc, LAT);
                    check("mosi_frame", last_frame, e.frame);
                    check("sclk_rises", last_rises, 16);
                    check("rdata_at_done", rdata, e.rdata);
                    hold_rdata = e.rdata;
                end
            end else if (!busy) begin
                check("rdata_hold", rdata, hold_rdata);
            end
        end
    end

    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d, output int acc);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", busy, 0);
        start = 1'b1; rw = r; addr = a; wdata = d;
        acc = cyc + 1;
        e.frame = {a, r, (r ? 8'h00 : d)};
        if (r) model_rdata = ref_mem[a];
        else   ref_mem[a] = d;
        e.rdata = model_rdata;
        e.acc   = acc;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
        check("busy_cs_after_accept", {busy, cs_n}, 2'b10);
    endtask

    task automatic wait_cycle(input int acc, input int n);
        int k;
        k = 0;
        while (cyc + 1 != acc + n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reach_cycle", cyc + 1 - acc, n);
    endtask

    task automatic pulse_at(input int acc, input int n);
        wait_cycle(acc, n);
        start = 1'b1; rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(k < 1000), 1);
        if (k >= 1000) exp_q.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        int         acc;
        int         acc2;
        logic       r_v;
        logic [6:0] a_v;
        logic [7:0] d_v;

        for (int i = 0; i < 128; i++) ref_mem[i] = init_byte(i);
        model_rdata = 8'h00;
        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        repeat (100) begin
            @(negedge clk);
            check("idle_outputs", {cs_n, sclk, mosi, busy, done, rdata}, 32'h1000);
        end

        issue(1'b0, 7'h05, 8'hA3, acc);
        wait_idle();

        issue(1'b1, 7'h2A, 8'hFF, acc);
        wait_idle();
        check("read_0x2A", rdata, 8'h5C);

        issue(1'b0, 7'h10, 8'h77, acc);
        pulse_at(acc, 10);
        pulse_at(acc, 139);
        issue(1'b1, 7'h10, 8'h00, acc2);
        check("accept_after_done", acc2 - acc, LAT + 1);
        wait_idle();

        issue(1'b1, 7'h2A, 8'h00, acc);
        wait_cycle(acc, 60);
        reset = 1'b1;
        model_rdata = 8'h00;
        #1;
        check("abort_outputs", {cs_n, sclk, busy, done, mosi}, 5'b10000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);

        issue(1'b0, 7'h22, 8'h99, acc);
        wait_idle();

        issue(1'b0, 7'h11, 8'h3C, acc);
        issue(1'b1, 7'h11, 8'h00, acc);
        wait_idle();
        check("loopback_rdata", rdata, 8'h3C);

        for (int i = 0; i < 24; i++) begin
            r_v = 1'($urandom_range(1, 0));
            a_v = ($urandom_range(3, 0) == 0) ? 7'($urandom) : 7'($urandom_range(7, 0));
            d_v = 8'($urandom);
            issue(r_v, a_v, d_v, acc);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        wait_idle();

        for (int i = 0; i < 128; i++) begin
            check($sformatf("mem_%0h", i), slv_mem[i], ref_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI initiator that issues single-byte read and write transactions to the 7-bit-address SPI memory over the four-wire bus (sclk, cs, mosi, miso). It sits on the host side of the FPGA. It accepts a one-cycle command from local logic, serialises a 16-bit frame, and returns the read byte with a done pulse. All bus timing is derived from the single system clock through a programmable divider, so that the memory's input conditioners see clean, slow edges.

## Interface
- CLK_DIV, 4: system clocks per SCLK half-period; legal range is 2 or more.
- CS_IDLE, 4: system clocks cs_n is held high after each frame before the next command is accepted; legal range is 1 or more.
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe, sampled only while busy=0.
- rw  in  1  1 = read, 0 = write; latched on accept.
- addr  in  7  memory address; latched on accept.
- wdata  in  8  write byte; latched on accept and ignored for reads.
- busy  out  1  high from the cycle after accept through the done cycle.
- done  out  1  one-cycle pulse at the end of the transaction.
- rdata  out  8  read byte; valid from done onward and held until the next read completes.
- sclk  out  1  SPI clock; idles low (mode 0).
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data to the memory.
- miso  in  1  serial data from the memory.

## Operation
- Frame is 16 bits, MSB first: {addr[6:0], rw, wdata[7:0]}.
  - For reads the trailing 8 MOSI bits are 0.
  - For reads the 8 MISO bits sampled during frame bits 7..0 form rdata.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: start=1 causes the command fields to be latched, and the state moves to SETUP.
  - SETUP: cs_n=0, sclk=0, mosi=frame[15]; lasts CLK_DIV cycles, then moves to SHIFT.
  - SHIFT: each bit takes CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
    - miso is sampled on the last cycle of each high phase.
    - mosi advances to the next bit in the first cycle of the next low phase.
    - After bit 0's high phase, the state moves to HOLD.
  - HOLD: sclk=0, cs_n=0; lasts CLK_DIV cycles, then moves to GAP.
  - GAP: cs_n=1; lasts CS_IDLE cycles. done=1 on the last GAP cycle, then the state moves to IDLE.
- rdata updates only on read transactions; writes leave it unchanged.
- start while busy=1 (including the done cycle) is ignored and not queued.
- Reset values: state IDLE, busy=0, done=0, rdata=0x00, sclk=0, cs_n=1, mosi=0.
- Reset mid-transaction aborts immediately with the same values; the memory sees cs_n rise.
- Counters:
  - Divider counter width is $clog2(CLK_DIV), counting 0..CLK_DIV-1.
  - Bit counter is 4 bits, counting 15 down to 0.
  - The GAP counter width is $clog2(CS_IDLE+1).

## Timing
- Accept at clk edge 0. busy=1 and cs_n=0 from cycle 1.
- cs_n stays low for 34*CLK_DIV cycles: SETUP, 32 half-periods, HOLD.
- cs_n is high for CS_IDLE cycles, with done on the last of them. busy=0 the following cycle.
- Total latency from accept to done is 34*CLK_DIV + CS_IDLE cycles. For the defaults this is 140; busy falls at cycle 141.
- mosi is stable for at least CLK_DIV cycles before each sclk rise and through the entire high phase.
- The memory launches miso after its conditioned falling edge. Sampling late in the high phase gives that launch a full half-period plus CLK_DIV-1 cycles of margin.
- Back-to-back commands are possible: start asserted in the cycle busy=0 is accepted that cycle.

## Structure
- Shared package spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD, GAP);
  - FRAME_BITS=16, ADDR_W=7, DATA_W=8;
  - RW_READ=1'b1 and RW_WRITE=1'b0.
- One natural sub-module, spi_sclk_gen. It owns the divider counter and emits:
  - sclk;
  - a one-cycle rise_pulse (first high cycle);
  - a one-cycle sample_pulse (last high cycle);
  - a one-cycle fall_pulse (first low cycle).
- The top-level FSM, frame shift register and rdata register consume these pulses.

## Test plan
- Reset, no start → cs_n=1, sclk=0, mosi=0, busy=0, rdata=0x00 held for 100 cycles.
- Write, addr=0x05, wdata=0xA3:
  - mosi sampled at each sclk rise reads 0x0AA3;
  - exactly 16 sclk rises occur;
  - done arrives 140 cycles after accept;
  - rdata is unchanged.
- Read, addr=0x2A, with a miso model returning 0x5C on bits 7..0 (launched on sclk fall) → first MOSI byte 0x55, rdata=0x5C at done.
- start pulsed at cycles 10 and 139 of a transaction → both ignored; one done only; a start in the cycle after done is accepted.
- reset asserted at cycle 60 of a read → same-cycle cs_n=1, sclk=0, busy=0, no done. A fresh write afterwards completes normally.
- Loopback against the SPI memory, write 0x3C to 0x11, then read 0x11 → rdata=0x3C.
